// File: rtl/md_unit.sv
// MIPS HI/LO multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
// Optional MD_FLUSH_EN adds a flush input that cancels a running operation.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_d, lo_d;
    logic          flush_w;

`ifdef MD_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Arithmetic works on the latched operands; op_q[0] set means unsigned.
    logic        sgn, neg_a, neg_b;
    logic [63:0] mul_a, mul_b, mul_p;
    logic [31:0] mag_a, mag_b, divisor, q_u, r_u, quo, rem;

    assign sgn     = ~op_q[0];
    assign neg_a   = sgn & a_q[31];
    assign neg_b   = sgn & b_q[31];
    assign mul_a   = {{32{neg_a}}, a_q};
    assign mul_b   = {{32{neg_b}}, b_q};
    assign mul_p   = mul_a * mul_b;

    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
    assign mag_a   = neg_a ? -a_q : a_q;
    assign mag_b   = neg_b ? -b_q : b_q;
    assign divisor = (b_q == 32'd0) ? 32'd1 : mag_b;
    assign q_u     = mag_a / divisor;
    assign r_u     = mag_a % divisor;
    assign quo     = (neg_a ^ neg_b) ? -q_u : q_u;
    assign rem     = neg_a ? -r_u : r_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi;
        lo_d    = lo;
        case (state_q)
            IDLE: begin
                if (start && !flush_w) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d = RUN;
                            cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            op_d    = op[1:0];
                            a_d     = a;
                            b_d     = b;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        if (!op_q[1]) begin
                            hi_d = mul_p[63:32];
                            lo_d = mul_p[31:0];
                        end else if (b_q != 32'd0) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi      <= hi_d;
            lo      <= lo_d;
            busy    <= (state_d == RUN);
        end
    end

endmodule
